// File: rtl/factor_scheduler.sv
// Trial-division factor scanner: walks d = 1..n against an external remainder unit,
// holds each divisor that divides n on the display for MAX_COUNT cycles, then keeps scanning.
module factor_scheduler #(
  parameter int MAX_COUNT = 10000000,
  parameter int WIDTH     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] number,
  output logic             div_req,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_ack,
  input  logic             div_rem_zero,
  output logic [WIDTH-1:0] disp_value,
  output logic             disp_valid,
  output logic             is_zero,
  output logic             busy,
  output logic             wrap
);

  localparam int             DW         = 24;
  localparam logic [DW-1:0]  DWELL_LOAD = DW'(MAX_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DISPLAY,
    S_ZERO
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_d;
  logic [DW-1:0]    r_dwell;
  logic [WIDTH-1:0] r_disp_value;
  logic             r_disp_valid;
  logic             r_is_zero;
  logic             r_busy;
  logic             r_div_req;
  logic             r_wrap;

  state_t           w_state_next;
  logic [WIDTH-1:0] w_n_next;
  logic [WIDTH-1:0] w_d_next;
  logic [DW-1:0]    w_dwell_next;
  logic [WIDTH-1:0] w_disp_value_next;
  logic             w_disp_valid_next;
  logic             w_is_zero_next;
  logic             w_busy_next;
  logic             w_div_req_next;
  logic             w_wrap_next;

  // Divisor advance: wrap back to 1 after d == n so d never exceeds n or overflows.
  logic             w_at_end;
  logic [WIDTH-1:0] w_d_adv;
  assign w_at_end = (r_d == r_n);
  assign w_d_adv  = w_at_end ? WIDTH'(1) : (r_d + WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_n          <= '0;
      r_d          <= WIDTH'(1);
      r_dwell      <= '0;
      r_disp_value <= '0;
      r_disp_valid <= 1'b0;
      r_is_zero    <= 1'b0;
      r_busy       <= 1'b0;
      r_div_req    <= 1'b0;
      r_wrap       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_n          <= w_n_next;
      r_d          <= w_d_next;
      r_dwell      <= w_dwell_next;
      r_disp_value <= w_disp_value_next;
      r_disp_valid <= w_disp_valid_next;
      r_is_zero    <= w_is_zero_next;
      r_busy       <= w_busy_next;
      r_div_req    <= w_div_req_next;
      r_wrap       <= w_wrap_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_n_next          = r_n;
    w_d_next          = r_d;
    w_dwell_next      = r_dwell;
    w_disp_value_next = r_disp_value;
    w_disp_valid_next = r_disp_valid;
    w_is_zero_next    = r_is_zero;
    w_busy_next       = r_busy;
    w_div_req_next    = r_div_req;
    w_wrap_next       = 1'b0;

    if (start) begin
      // start always restarts, even mid-handshake; a coincident ack is dropped
      w_n_next       = number;
      w_d_next       = WIDTH'(1);
      w_dwell_next   = '0;
      w_div_req_next = 1'b0;
      w_busy_next    = 1'b1;
      w_disp_value_next = '0;
      if (number == '0) begin
        w_state_next      = S_ZERO;
        w_is_zero_next    = 1'b1;
        w_disp_valid_next = 1'b1;
      end else begin
        w_state_next      = S_ISSUE;
        w_is_zero_next    = 1'b0;
        w_disp_valid_next = 1'b0;
      end
    end else begin
      case (r_state)
        S_ISSUE: begin
          if (!r_div_req) begin
            w_div_req_next = 1'b1;
          end else if (div_ack) begin
            w_div_req_next = 1'b0;
            if (div_rem_zero) begin
              w_state_next      = S_DISPLAY;
              w_disp_value_next = r_d;
              w_disp_valid_next = 1'b1;
              w_dwell_next      = DWELL_LOAD;
            end else begin
              w_d_next    = w_d_adv;
              w_wrap_next = w_at_end;
            end
          end
        end
        S_DISPLAY: begin
          if (r_dwell == '0) begin
            w_state_next = S_ISSUE;
            w_d_next     = w_d_adv;
            w_wrap_next  = w_at_end;
          end else begin
            w_dwell_next = r_dwell - DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign div_req      = r_div_req;
  assign div_dividend = r_n;
  assign div_divisor  = r_d;
  assign disp_value   = r_disp_value;
  assign disp_valid   = r_disp_valid;
  assign is_zero      = r_is_zero;
  assign busy         = r_busy;
  assign wrap         = r_wrap;

endmodule

// File: tb/tb_factor_scheduler.sv
// Scoreboard bench for factor_scheduler: expected factor/wrap events are queued at start,
// a monitor pops them as the DUT displays factors or pulses wrap; a remainder-unit model acks requests.
module tb_factor_scheduler;

  localparam int MAXC = 4;
  localparam int W    = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] number;
  logic         div_req;
  logic [W-1:0] div_dividend;
  logic [W-1:0] div_divisor;
  logic         div_ack;
  logic         div_rem_zero;
  logic [W-1:0] disp_value;
  logic         disp_valid;
  logic         is_zero;
  logic         busy;
  logic         wrap;

  logic m_ack, m_rz, f_ack, f_rz;
  assign div_ack      = m_ack | f_ack;
  assign div_rem_zero = m_rz | f_rz;

  factor_scheduler #(.MAX_COUNT(MAXC), .WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .number       (number),
    .div_req      (div_req),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_ack      (div_ack),
    .div_rem_zero (div_rem_zero),
    .disp_value   (disp_value),
    .disp_valid   (disp_valid),
    .is_zero      (is_zero),
    .busy         (busy),
    .wrap         (wrap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];     // factor values, -1 marks an expected wrap pulse
  bit ack_en    = 1'b1;
  bit force_lat = 1'b0;
  int cur_num   = 0;

  task automatic chk(input int act, input int exp, input string name);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0d (t=%0t)", name, act, $time);
    end
  endtask

  // Remainder-unit model: acks after 1..3 cycles (5 when forced), checks operand stability.
  initial begin : ack_model
    int wait_cnt;
    int lat;
    int dd;
    int dv;
    m_ack = 1'b0;
    m_rz  = 1'b0;
    wait_cnt = 0;
    lat = 1;
    dd = 0;
    dv = 0;
    forever begin
      @(negedge clk);
      if (m_ack) begin
        m_ack = 1'b0;
        m_rz  = 1'b0;
        chk(int'(div_req), 0, "req_drop_after_ack");
      end else if (ack_en && div_req) begin
        if (wait_cnt == 0) begin
          dd  = int'(div_dividend);
          dv  = int'(div_divisor);
          lat = force_lat ? 5 : int'($urandom_range(1, 3));
          chk(dd, cur_num, "req_dividend");
          wait_cnt = 1;
        end else begin
          chk(int'(div_divisor), dv, "req_divisor_stable");
          chk(int'(div_dividend), dd, "req_dividend_stable");
        end
        if (wait_cnt == lat) begin
          m_ack = 1'b1;
          m_rz  = (dv != 0) && ((dd % dv) == 0);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: factor event = ack with remainder zero while a request was pending.
  initial begin : monitor
    bit prev_req;
    bit meas;
    int gap;
    int e;
    prev_req = 1'b0;
    meas = 1'b0;
    gap = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || start) begin
        meas = 1'b0;
      end else begin
        if (meas) begin
          if (div_req) begin
            chk(gap, MAXC + 1, "dwell_gap");
            meas = 1'b0;
          end else begin
            gap++;
          end
        end
        if (prev_req && div_ack && div_rem_zero && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk(int'(disp_value), e, "factor_value");
          chk(int'(disp_valid), 1, "factor_valid");
          meas = 1'b1;
          gap = 1;
        end
        if (wrap && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk(wrap ? -1 : 0, e, "wrap_event");
        end
      end
      prev_req = div_req;
    end
  end

  task automatic start_num(input int n);
    cur_num = n;
    start  = 1'b1;
    number = W'(n);
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int c;
    c = 0;
    while (exp_q.size() > 0 && c < 6000) begin
      @(negedge clk);
      c++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d events left, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin : main
    int c;
    int seen;
    rst = 1'b1;
    start = 1'b0;
    number = '0;
    f_ack = 1'b0;
    f_rz = 1'b0;
    repeat (3) @(negedge clk);
    chk(int'(busy), 0, "rst_busy");
    chk(int'(div_req), 0, "rst_div_req");
    chk(int'(disp_valid), 0, "rst_disp_valid");
    chk(int'(disp_value), 0, "rst_disp_value");
    chk(int'(is_zero), 0, "rst_is_zero");
    chk(int'(wrap), 0, "rst_wrap");
    rst = 1'b0;
    @(negedge clk);

    // full pass of 12, then back to 1
    exp_q = {1, 2, 3, 4, 6, 12, -1, 1};
    start_num(12);
    wait_empty("n12");

    // prime: only 1 and 13
    exp_q = {1, 13, -1, 1};
    start_num(13);
    wait_empty("n13");

    // slow remainder unit, 5-cycle ack
    force_lat = 1'b1;
    exp_q = {1, 5, -1, 1};
    start_num(5);
    wait_empty("n5_slow");
    force_lat = 1'b0;

    // abort 12 while factor 4 is on display
    exp_q = {1, 2, 3, 4};
    start_num(12);
    wait_empty("n12_part");
    exp_q = {1, 2, 3, 6, -1, 1};
    start_num(6);
    chk(int'(disp_valid), 0, "abort_disp_valid");
    chk(int'(is_zero), 0, "abort_is_zero");
    chk(int'(busy), 1, "abort_busy");
    chk(int'(div_req), 0, "abort_div_req");
    chk(int'(div_divisor), 1, "abort_divisor");
    chk(int'(div_dividend), 6, "abort_dividend");
    wait_empty("n6");

    // zero
    start_num(0);
    chk(int'(is_zero), 1, "zero_is_zero");
    chk(int'(disp_value), 0, "zero_disp_value");
    chk(int'(disp_valid), 1, "zero_disp_valid");
    chk(int'(busy), 1, "zero_busy");
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (div_req) seen = 1;
    end
    chk(seen, 0, "zero_no_req");

    // n=1: each pass shows 1 then wraps
    exp_q = {1, -1, 1, -1, 1};
    start_num(1);
    wait_empty("n1");

    // largest operand, wrap without overflow
    exp_q = {1, 3, 5, 15, 17, 51, 85, 255, -1, 1};
    start_num(255);
    wait_empty("n255");

    // reset with start during a pending request, then a late ack
    start_num(12);
    c = 0;
    while (!div_req && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk(int'(div_req), 1, "pre_rst_req");
    rst = 1'b1;
    start = 1'b1;
    number = W'(7);
    @(posedge clk);
    #1;
    chk(int'(div_req), 0, "rst2_div_req");
    chk(int'(busy), 0, "rst2_busy");
    chk(int'(disp_valid), 0, "rst2_disp_valid");
    chk(int'(disp_value), 0, "rst2_disp_value");
    chk(int'(is_zero), 0, "rst2_is_zero");
    chk(int'(wrap), 0, "rst2_wrap");
    chk(int'(div_dividend), 0, "rst2_dividend");
    chk(int'(div_divisor), 1, "rst2_divisor");
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    ack_en = 1'b0;
    f_ack = 1'b1;
    f_rz = 1'b1;
    @(negedge clk);
    f_ack = 1'b0;
    f_rz = 1'b0;
    repeat (3) @(negedge clk);
    chk(int'(busy), 0, "late_ack_busy");
    chk(int'(div_req), 0, "late_ack_div_req");
    chk(int'(disp_valid), 0, "late_ack_disp_valid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/factor_scheduler.md
FACTOR_SCHEDULER -- requirements
Module: factor_scheduler

Interface
REQ-001 Parameter MAX_COUNT, default 10000000, dwell cycles each found factor is held on the display (legal range 2..2^24-1).
REQ-002 Parameter WIDTH, default 8, operand width of number and divisor.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse; latch number and (re)start factor scan.
REQ-006 number  input  WIDTH  value to factorize, sampled only when start=1.
REQ-007 div_req  output  1  request to external remainder unit; held until div_ack.
REQ-008 div_dividend  output  WIDTH  latched number; stable while div_req=1.
REQ-009 div_divisor  output  WIDTH  current trial divisor d; stable while div_req=1.
REQ-010 div_ack  input  1  remainder unit done; ignored when div_req=0.
REQ-011 div_rem_zero  input  1  dividend mod divisor == 0; valid only in the div_ack cycle.
REQ-012 disp_value  output  WIDTH  factor currently shown.
REQ-013 disp_valid  output  1  disp_value holds a confirmed factor.
REQ-014 is_zero  output  1  latched number is 0.
REQ-015 busy  output  1  scheduler not in IDLE.
REQ-016 wrap  output  1  one-cycle pulse when the scan passes d=n and restarts at d=1.

Function
REQ-017 States SHALL be IDLE, ISSUE, DISPLAY, ZERO; all outputs registered.
REQ-018 IDLE: busy=0, div_req=0, disp_valid=0; start=1 -> latch n=number, d=1; next state ZERO if number==0, else ISSUE.
REQ-019 ISSUE: div_req=1 with div_dividend=n, div_divisor=d, first asserted the cycle after entry; held unchanged until div_ack=1 sampled.
REQ-020 div_req SHALL drop the cycle after the ack cycle; no back-to-back request without at least one idle cycle.
REQ-021 Ack with div_rem_zero=1 -> DISPLAY; disp_value=d, disp_valid=1 from next cycle; dwell counter loaded.
REQ-022 Ack with div_rem_zero=0 -> advance d, remain in ISSUE.
REQ-023 DISPLAY SHALL last exactly MAX_COUNT cycles (disp_valid=1 throughout), then advance d and return to ISSUE.
REQ-024 Advance d: if d==n then d=1 and wrap=1 for one cycle, else d=d+1; d never exceeds n, no WIDTH overflow (n=2^WIDTH-1 wraps to 1).
REQ-025 disp_value/disp_valid SHALL hold last factor during ISSUE scans (disp_valid stays 1 once any factor found, cleared only by start or rst).
REQ-026 Scan SHALL cycle indefinitely (1, ..., n, 1, ...) until rst; no self-return to IDLE.
REQ-027 ZERO: is_zero=1, disp_value=0, disp_valid=1, div_req=0; held until start or rst.
REQ-028 start while busy SHALL abort immediately: div_req=0 next cycle, disp_valid=0, is_zero=0, re-latch number, d=1, enter ZERO/ISSUE; any pending div_ack in that cycle ignored.
REQ-029 start and div_ack in same cycle: start wins.
REQ-030 n=1: only factor 1; every pass displays 1 then wraps.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, n=0, d=1, dwell=0, disp_value=0, disp_valid=0, is_zero=0, busy=0, div_req=0, wrap=0, overriding start.
REQ-032 rst mid-handshake SHALL drop div_req next cycle; a subsequent div_ack SHALL be ignored.

Verification (MAX_COUNT=4, ack model 1-3 cycles)
REQ-033 start, number=12 -> displayed sequence 1,2,3,4,6,12, each disp_valid for exactly 4 cycles, wrap pulse after d=12, then 1 again.
REQ-034 start, number=0 -> ZERO within 1 cycle: is_zero=1, disp_value=0, div_req never asserted.
REQ-035 start, number=13 -> displays 1, 13 only; divisors 2..12 issued with div_rem_zero=0; wrap after 13.
REQ-036 div_ack delayed 5 cycles -> div_req, div_dividend, div_divisor stable all 5 cycles; drop one cycle after ack.
REQ-037 start number=6 mid-DISPLAY of 12's factor 4 -> next cycle disp_valid=0, d=1; sequence 1,2,3,6 follows.
REQ-038 rst asserted during ISSUE with start=1 -> all outputs at reset values next cycle, state IDLE, late div_ack ignored.
